// File: rtl/opl_pkg.sv
// opl_pkg: shared action-field offsets, IOQ header defaults and FSM encodings for the output-port-lookup forwarder
package opl_pkg;
  localparam int ACT_DROP_FROM_MSB = 0;
  localparam int ACT_PUNT_FROM_MSB = 1;
  localparam logic [7:0] IOQ_HDR_CTRL_DEF = 8'hFF;
  localparam int DST_PORT_POS_DEF = 0;
  typedef enum logic [1:0] {
    WAIT_ACTION = 2'd0,
    FORWARD     = 2'd1,
    DROP        = 2'd2
  } state_t;
endpackage

// File: rtl/opl_action_forwarder_if.sv
// opl_action_forwarder_if: packet FIFO, action FIFO and output bus; slave = forwarder side, master = environment side
interface opl_action_forwarder_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int CTRL_WIDTH   = DATA_WIDTH / 8,
  parameter int ACTION_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   in_fifo_data;
  logic [CTRL_WIDTH-1:0]   in_fifo_ctrl;
  logic                    in_fifo_empty;
  logic                    in_fifo_rd_en;
  logic [ACTION_WIDTH-1:0] action;
  logic                    action_fifo_empty;
  logic                    action_rd_en;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [CTRL_WIDTH-1:0]   out_ctrl;
  logic                    out_wr;
  logic                    out_rdy;
  modport slave (
    input  in_fifo_data, in_fifo_ctrl, in_fifo_empty, action, action_fifo_empty, out_rdy,
    output in_fifo_rd_en, action_rd_en, out_data, out_ctrl, out_wr
  );
  modport master (
    output in_fifo_data, in_fifo_ctrl, in_fifo_empty, action, action_fifo_empty, out_rdy,
    input  in_fifo_rd_en, action_rd_en, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/opl_sec_timer.sv
// opl_sec_timer: free-running seconds counter; ports clk, reset (sync, active-high), s_counter (seconds since reset)
module opl_sec_timer #(
  parameter int CLK_PERIOD_NS = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] s_counter
);
  localparam logic [27:0] NS_MAX = 28'(1000000000 / CLK_PERIOD_NS - 1);
  logic [27:0] ns_counter;
  always_ff @(posedge clk) begin
    if (reset) begin
      ns_counter <= '0;
      s_counter  <= '0;
    end else if (ns_counter == NS_MAX) begin
      ns_counter <= '0;
      s_counter  <= s_counter + 32'd1;
    end else begin
      ns_counter <= ns_counter + 28'd1;
    end
  end
endmodule

// File: rtl/opl_action_forwarder.sv
// opl_action_forwarder: pairs packets with lookup actions, rewrites IOQ dst-port, forwards/punts/drops; ports clk, reset, bus (slave), stat pulses, s_counter (live only with OPL_FWD_SEC_TIMER_EN)
module opl_action_forwarder
  import opl_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int ACTION_WIDTH      = 32,
  parameter logic [CTRL_WIDTH-1:0] IOQ_HDR_CTRL = CTRL_WIDTH'(IOQ_HDR_CTRL_DEF),
  parameter int DST_PORT_POS      = DST_PORT_POS_DEF,
  parameter logic [NUM_OUTPUT_QUEUES-1:0] CPU_PORT_MASK = NUM_OUTPUT_QUEUES'(2),
  parameter int CLK_PERIOD_NS     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  opl_action_forwarder_if.slave        bus,
  output logic                         pkt_fwd_pulse,
  output logic                         pkt_drop_pulse,
  output logic                         pkt_punt_pulse,
  output logic [NUM_OUTPUT_QUEUES-1:0] port_fwd_pulse,
  output logic [31:0]                  s_counter
);
  state_t state, state_n;
  logic in_hdr, punt_r, go, dec_drop, dec_punt, eop, hdr_word;
  logic [NUM_OUTPUT_QUEUES-1:0] mask_r, act_mask, dec_mask;
  logic [DATA_WIDTH-1:0] wdata;
  always_comb begin
    act_mask   = bus.action[NUM_OUTPUT_QUEUES-1:0];
    dec_punt   = bus.action[ACTION_WIDTH-1-ACT_PUNT_FROM_MSB];
    dec_drop   = bus.action[ACTION_WIDTH-1-ACT_DROP_FROM_MSB] || (act_mask == '0 && !dec_punt);
    dec_mask   = dec_punt ? CPU_PORT_MASK : act_mask;
    go         = !bus.action_fifo_empty && !bus.in_fifo_empty;
    bus.in_fifo_rd_en = (state == FORWARD) ? (!bus.in_fifo_empty && bus.out_rdy) :
                        (state == DROP) ? !bus.in_fifo_empty : 1'b0;
    eop        = bus.in_fifo_rd_en && !in_hdr && bus.in_fifo_ctrl != '0;
    state_n    = (state == WAIT_ACTION) ? (go ? (dec_drop ? DROP : FORWARD) : WAIT_ACTION) :
                 (eop ? WAIT_ACTION : state);
    bus.action_rd_en = eop;
    pkt_fwd_pulse    = eop && state == FORWARD;
    pkt_drop_pulse   = eop && state == DROP;
    pkt_punt_pulse   = eop && state == FORWARD && punt_r;
    port_fwd_pulse   = pkt_fwd_pulse ? mask_r : '0;
    hdr_word   = in_hdr && bus.in_fifo_ctrl == IOQ_HDR_CTRL;
    wdata      = bus.in_fifo_data;
    // A 16-bit field is always written so upper dst bits are zeroed when fewer than 16 queues exist
    if (hdr_word) wdata[DST_PORT_POS +: 16] = 16'(mask_r);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_ACTION;
      in_hdr       <= 1'b0;
      mask_r       <= '0;
      punt_r       <= 1'b0;
      bus.out_wr   <= 1'b0;
      bus.out_data <= '0;
      bus.out_ctrl <= '0;
    end else begin
      state      <= state_n;
      bus.out_wr <= bus.in_fifo_rd_en && state == FORWARD;
      // Decision registers track the action head while waiting; the value present on leaving is the one kept
      if (state == WAIT_ACTION) begin
        in_hdr <= 1'b1;
        mask_r <= dec_mask;
        punt_r <= dec_punt && !dec_drop;
      end else if (bus.in_fifo_rd_en && bus.in_fifo_ctrl == '0) begin
        in_hdr <= 1'b0;
      end
      if (bus.in_fifo_rd_en && state == FORWARD) begin
        bus.out_data <= wdata;
        bus.out_ctrl <= bus.in_fifo_ctrl;
      end
    end
  end
`ifdef OPL_FWD_SEC_TIMER_EN
  opl_sec_timer #(.CLK_PERIOD_NS(CLK_PERIOD_NS)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .s_counter (s_counter)
  );
`else
  assign s_counter = '0;
`endif
endmodule

// File: tb/tb_opl_action_forwarder.sv
// tb_opl_action_forwarder: directed self-checking bench for opl_action_forwarder
module tb_opl_action_forwarder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  opl_action_forwarder_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ACTION_WIDTH(32)) bus ();
  logic pkt_fwd_pulse, pkt_drop_pulse, pkt_punt_pulse;
  logic [7:0] port_fwd_pulse;
  logic [31:0] s_counter;
  opl_action_forwarder #(
    .DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_OUTPUT_QUEUES(8), .ACTION_WIDTH(32),
    .IOQ_HDR_CTRL(8'hFF), .DST_PORT_POS(0), .CPU_PORT_MASK(8'h02), .CLK_PERIOD_NS(100_000_000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pkt_fwd_pulse(pkt_fwd_pulse), .pkt_drop_pulse(pkt_drop_pulse), .pkt_punt_pulse(pkt_punt_pulse),
    .port_fwd_pulse(port_fwd_pulse), .s_counter(s_counter)
  );
  int checks = 0, errors = 0;
  logic [71:0] pq[$], oq[$], eq[$];
  logic [31:0] aq[$];
  int n_fwd, n_drop, n_punt, n_arp, n_rd;
  logic [7:0] port_acc;
  logic rdy_toggle = 1'b0, rdy_ph = 1'b0;
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    bus.in_fifo_empty     = pq.size() == 0;
    bus.in_fifo_data      = pq.size() != 0 ? pq[0][63:0] : 64'h0;
    bus.in_fifo_ctrl      = pq.size() != 0 ? pq[0][71:64] : 8'h0;
    bus.action_fifo_empty = aq.size() == 0;
    bus.action            = aq.size() != 0 ? aq[0] : 32'h0;
    bus.out_rdy           = rdy_toggle ? rdy_ph : 1'b1;
    rdy_ph                = ~rdy_ph;
  endtask
  task automatic cyc();
    @(negedge clk);
    drive();
    #1;
    if (bus.out_wr) oq.push_back({bus.out_ctrl, bus.out_data});
    if (pkt_fwd_pulse) n_fwd++;
    if (pkt_drop_pulse) n_drop++;
    if (pkt_punt_pulse) n_punt++;
    port_acc |= port_fwd_pulse;
    if (bus.in_fifo_rd_en) begin
      n_rd++;
      if (pq.size() != 0) void'(pq.pop_front());
    end
    if (bus.action_rd_en) begin
      n_arp++;
      if (aq.size() != 0) void'(aq.pop_front());
    end
  endtask
  task automatic clear_stats();
    n_fwd = 0; n_drop = 0; n_punt = 0; n_arp = 0; n_rd = 0; port_acc = '0;
    oq.delete(); eq.delete();
  endtask
  task automatic run_pkt(input string tag);
    int k = 0;
    while ((pq.size() != 0 || aq.size() != 0) && k < 100) begin
      cyc();
      k++;
    end
    repeat (3) cyc();
    chk({tag, "_done"}, 72'(k < 100), 72'd1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive();
    @(negedge clk);
    drive();
    #1;
    chk("rst_out_wr", 72'(bus.out_wr), 72'd0);
    chk("rst_s_counter", 72'(s_counter), 72'd0);
    reset = 1'b0;
  endtask
  initial begin
    clear_stats();
    drive();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_data", {bus.out_ctrl, bus.out_data}, 72'h0);
    chk("rst_pulses", 72'({pkt_fwd_pulse, pkt_drop_pulse, pkt_punt_pulse, port_fwd_pulse}), 72'h0);
    chk("rst_rd_en", 72'({bus.in_fifo_rd_en, bus.action_rd_en}), 72'h0);
    reset = 1'b0;
`ifdef OPL_FWD_SEC_TIMER_EN
    repeat (10) cyc();
    chk("timer_10", 72'(s_counter), 72'd1);
    repeat (5) cyc();
    do_reset();
    repeat (20) cyc();
    chk("timer_20", 72'(s_counter), 72'd2);
`else
    repeat (12) cyc();
    chk("timer_off", 72'(s_counter), 72'd0);
`endif
    do_reset();
    clear_stats();
    // packet without an action must not be popped
    pq = '{{8'hFF, 64'h1234_5678_9ABC_FFFF}, {8'h00, 64'h1111_1111_1111_1111},
           {8'h00, 64'h2222_2222_2222_2222}, {8'h80, 64'h3333_3333_3333_3333}};
    repeat (5) cyc();
    chk("wait_no_pop", 72'(n_rd), 72'd0);
    chk("wait_pq", 72'(pq.size()), 72'd4);
    aq.push_back(32'h0000_0005);
    run_pkt("t1");
    chk("t1_writes", 72'(oq.size()), 72'd4);
    chk("t1_hdr", oq[0], {8'hFF, 64'h1234_5678_9ABC_0005});
    chk("t1_w1", oq[1], {8'h00, 64'h1111_1111_1111_1111});
    chk("t1_w3", oq[3], {8'h80, 64'h3333_3333_3333_3333});
    chk("t1_fwd", 72'(n_fwd), 72'd1);
    chk("t1_port", 72'(port_acc), 72'h05);
    chk("t1_arp", 72'(n_arp), 72'd1);
    chk("t1_nodrop", 72'(n_drop), 72'd0);
    clear_stats();
    pq = '{{8'hFF, 64'hAAAA_0000_0000_00FF}, {8'h00, 64'h4444}, {8'h40, 64'h5555}};
    aq.push_back(32'h8000_0005);
    run_pkt("t2");
    chk("t2_drained", 72'(pq.size()), 72'd0);
    chk("t2_writes", 72'(oq.size()), 72'd0);
    chk("t2_drop", 72'(n_drop), 72'd1);
    chk("t2_fwd", 72'(n_fwd), 72'd0);
    chk("t2_port", 72'(port_acc), 72'h00);
    chk("t2_arp", 72'(n_arp), 72'd1);
    clear_stats();
    pq = '{{8'hFF, 64'hBEEF_0000_0000_FF10}, {8'h00, 64'h6666}, {8'h01, 64'h7777}};
    aq.push_back(32'h4000_0010);
    run_pkt("t3");
    chk("t3_writes", 72'(oq.size()), 72'd3);
    chk("t3_hdr", oq[0], {8'hFF, 64'hBEEF_0000_0000_0002});
    chk("t3_fwd", 72'(n_fwd), 72'd1);
    chk("t3_punt", 72'(n_punt), 72'd1);
    chk("t3_port", 72'(port_acc), 72'h02);
    clear_stats();
    pq = '{{8'hFF, 64'h0}, {8'h00, 64'h8888}, {8'h02, 64'h9999}};
    aq.push_back(32'h0000_0000);
    run_pkt("t4");
    chk("t4_drop", 72'(n_drop), 72'd1);
    chk("t4_port", 72'(port_acc), 72'h00);
    chk("t4_writes", 72'(oq.size()), 72'd0);
    chk("t4_drained", 72'(pq.size()), 72'd0);
    clear_stats();
    pq = '{{8'hFF, 64'hC0DE_0000_1234_5678}, {8'h01, 64'hA1}, {8'h00, 64'hA2},
           {8'h00, 64'hA3}, {8'h00, 64'hA4}, {8'h04, 64'hA5}};
    eq = '{{8'hFF, 64'hC0DE_0000_1234_0081}, {8'h01, 64'hA1}, {8'h00, 64'hA2},
           {8'h00, 64'hA3}, {8'h00, 64'hA4}, {8'h04, 64'hA5}};
    aq.push_back(32'h0000_0081);
    rdy_toggle = 1'b1;
    run_pkt("t5");
    rdy_toggle = 1'b0;
    chk("t5_writes", 72'(oq.size()), 72'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t5_w%0d", i), oq[i], eq[i]);
    chk("t5_fwd", 72'(n_fwd), 72'd1);
    chk("t5_port", 72'(port_acc), 72'h81);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
